// File: rtl/fft_pkg.sv
// fft_pkg: shared types, constants and the Q1.15 saturation helper for the
// FFT butterfly datapath.
//   Q15_SHIFT        - product renormalisation shift
//   SAT_MAX/SAT_MIN  - 16-bit signed clamp limits
//   sample_t         - complex sample, signed Q1.15 re/im
//   sat16_t, sat16() - clamp a wide signed value to 16 bits, with overflow bit
package fft_pkg;

  localparam int Q15_SHIFT = 15;
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

  localparam logic signed [32:0] SAT_MAX_W = 33'sd32767;
  localparam logic signed [32:0] SAT_MIN_W = -33'sd32768;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t;

  typedef struct packed {
    logic signed [15:0] val;
    logic               ovf;
  } sat16_t;

  // Every wide intermediate in the butterfly fits in 33 signed bits.
  function automatic sat16_t sat16(input logic signed [32:0] x);
    sat16_t r;
    if (x > SAT_MAX_W) begin
      r.val = 16'sh7fff;
      r.ovf = 1'b1;
    end else if (x < SAT_MIN_W) begin
      r.val = 16'sh8000;
      r.ovf = 1'b1;
    end else begin
      r.val = x[15:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_pipe_if.sv
// fft_bfly_pipe_if: streaming bus of the butterfly stage.
//   upstream   : in_valid/in_ready, a/b/w operands, in_tag
//   downstream : out_valid/out_ready, y0/y1 results, out_tag
//   status     : sat_flag (sticky), sat_clr
// master = the environment (sample buffers), slave = the butterfly.
interface fft_bfly_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] a_re, a_im;
  logic signed [DATA_WIDTH-1:0] b_re, b_im;
  logic signed [DATA_WIDTH-1:0] w_re, w_im;
  logic [TAG_WIDTH-1:0]         in_tag;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] y0_re, y0_im;
  logic signed [DATA_WIDTH-1:0] y1_re, y1_im;
  logic [TAG_WIDTH-1:0]         out_tag;

  logic                         sat_flag;
  logic                         sat_clr;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, in_tag,
    output out_ready, sat_clr,
    input  in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, out_tag, sat_flag
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, in_tag,
    input  out_ready, sat_clr,
    output in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, out_tag, sat_flag
  );
endinterface

// File: rtl/fft_cmul_sat.sv
// fft_cmul_sat: combinational complex multiply t = b * w in Q1.15.
//   b_i, w_i : complex operands
//   t_o      : product, floor-renormalised and saturated to 16 bits
//   sat_o    : either component saturated
module fft_cmul_sat
  import fft_pkg::*;
(
  input  sample_t b_i,
  input  sample_t w_i,
  output sample_t t_o,
  output logic    sat_o
);

  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0] s_re, s_im;
  logic signed [32:0] sh_re, sh_im;
  sat16_t             r_re, r_im;

  always_comb begin
    p_rr = $signed(b_i.re) * $signed(w_i.re);
    p_ii = $signed(b_i.im) * $signed(w_i.im);
    p_ri = $signed(b_i.re) * $signed(w_i.im);
    p_ir = $signed(b_i.im) * $signed(w_i.re);
    // One guard bit: (-32768)^2 + (-32768)^2 does not fit in 32 bits.
    s_re = {p_rr[31], p_rr} - {p_ii[31], p_ii};
    s_im = {p_ri[31], p_ri} + {p_ir[31], p_ir};
    // Arithmetic shift floors; no rounding term by design.
    sh_re = s_re >>> Q15_SHIFT;
    sh_im = s_im >>> Q15_SHIFT;
    r_re  = sat16(sh_re);
    r_im  = sat16(sh_im);
    t_o.re = r_re.val;
    t_o.im = r_im.val;
    sat_o  = r_re.ovf | r_im.ovf;
  end

endmodule

// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: three-stage radix-2 DIT butterfly, y0 = a + b*w, y1 = a - b*w,
// signed Q1.15 with saturation, valid/ready on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fft_bfly_pipe_if slave (operands, results, tag, sat status)
// Stages: S1 registers inputs, S2 registers a, t = b*w and tag, S3 registers
// y0/y1 and drives the outputs. A stage loads when empty or when the next
// stage loads, so bubbles collapse and the pipe holds up to three butterflies.
// Build option: define BFLY_SCALE_EN for a 1/2 scale on the S3 add/sub
// (floor of the 17-bit sums); S3 then cannot saturate.
module fft_bfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_bfly_pipe_if.slave bus
);

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("fft_bfly_pipe: only DATA_WIDTH = 16 is supported");
  end

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  sample_t              a1_q, a1_d, b1_q, b1_d, w1_q, w1_d;
  logic [TAG_WIDTH-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  sample_t              a2_q, a2_d, t2_q, t2_d;
  sample_t              y0_q, y0_d, y1_q, y1_d;
  logic                 sat_q, sat_d;

  logic                 ld1, ld2, ld3;
  logic                 in_rdy, accept;
  sample_t              t_mul;
  logic                 mul_sat;
  logic signed [16:0]   s0_re, s0_im, s1_re, s1_im;
  sample_t              y0_n, y1_n;
  logic                 as_sat;
  logic                 sat_set;

  fft_cmul_sat u_cmul (
    .b_i   (b1_q),
    .w_i   (w1_q),
    .t_o   (t_mul),
    .sat_o (mul_sat)
  );

  // S3 add/sub on 17-bit sign-extended operands.
  always_comb begin
    s0_re = {a2_q.re[15], a2_q.re} + {t2_q.re[15], t2_q.re};
    s0_im = {a2_q.im[15], a2_q.im} + {t2_q.im[15], t2_q.im};
    s1_re = {a2_q.re[15], a2_q.re} - {t2_q.re[15], t2_q.re};
    s1_im = {a2_q.im[15], a2_q.im} - {t2_q.im[15], t2_q.im};
`ifdef BFLY_SCALE_EN
    // Dropping the LSB of a 17-bit two's-complement sum is a floor divide by 2.
    y0_n.re = s0_re[16:1];
    y0_n.im = s0_im[16:1];
    y1_n.re = s1_re[16:1];
    y1_n.im = s1_im[16:1];
    as_sat  = 1'b0;
`else
    begin
      sat16_t r0r, r0i, r1r, r1i;
      r0r = sat16({{16{s0_re[16]}}, s0_re});
      r0i = sat16({{16{s0_im[16]}}, s0_im});
      r1r = sat16({{16{s1_re[16]}}, s1_re});
      r1i = sat16({{16{s1_im[16]}}, s1_im});
      y0_n.re = r0r.val;
      y0_n.im = r0i.val;
      y1_n.re = r1r.val;
      y1_n.im = r1i.val;
      as_sat  = r0r.ovf | r0i.ovf | r1r.ovf | r1i.ovf;
    end
`endif
  end

  always_comb begin
    ld3 = !v3_q | bus.out_ready;
    ld2 = !v2_q | ld3;
    ld1 = !v1_q | ld2;
    // Gating with rst_n holds in_ready low for the whole reset assertion.
    in_rdy = rst_n & ld1;
    accept = bus.in_valid & in_rdy;

    v1_d   = v1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    w1_d   = w1_q;
    tag1_d = tag1_q;
    v2_d   = v2_q;
    a2_d   = a2_q;
    t2_d   = t2_q;
    tag2_d = tag2_q;
    v3_d   = v3_q;
    y0_d   = y0_q;
    y1_d   = y1_q;
    tag3_d = tag3_q;

    if (ld1) begin
      v1_d = accept;
      if (accept) begin
        a1_d   = '{re: bus.a_re, im: bus.a_im};
        b1_d   = '{re: bus.b_re, im: bus.b_im};
        w1_d   = '{re: bus.w_re, im: bus.w_im};
        tag1_d = bus.in_tag;
      end
    end

    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        a2_d   = a1_q;
        t2_d   = t_mul;
        tag2_d = tag1_q;
      end
    end

    // S3 data only moves with a valid word, keeping the outputs steady
    // under back-pressure and across bubbles.
    if (ld3) begin
      v3_d = v2_q;
      if (v2_q) begin
        y0_d   = y0_n;
        y1_d   = y1_n;
        tag3_d = tag2_q;
      end
    end

    sat_set = (ld2 & v1_q & mul_sat) | (ld3 & v2_q & as_sat);
    if (sat_set)          sat_d = 1'b1;
    else if (bus.sat_clr) sat_d = 1'b0;
    else                  sat_d = sat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      w1_q   <= '0;
      tag1_q <= '0;
      a2_q   <= '0;
      t2_q   <= '0;
      tag2_q <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      tag3_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      w1_q   <= w1_d;
      tag1_q <= tag1_d;
      a2_q   <= a2_d;
      t2_q   <= t2_d;
      tag2_q <= tag2_d;
      y0_q   <= y0_d;
      y1_q   <= y1_d;
      tag3_q <= tag3_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = v3_q;
  assign bus.y0_re     = y0_q.re;
  assign bus.y0_im     = y0_q.im;
  assign bus.y1_re     = y1_q.re;
  assign bus.y1_im     = y1_q.im;
  assign bus.out_tag   = tag3_q;
  assign bus.sat_flag  = sat_q;

endmodule
